// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl
//
// Receive-side frame parser for ECG sample uploads arriving over the UART.
// A frame is: HEADER byte, N_SAMPLES big-endian 16-bit samples, then an 8-bit
// checksum (mod-256 sum of the 2*N_SAMPLES data bytes). Each completed sample
// is written to the sample buffer; a frame whose checksum matches is held as
// valid until the consumer acknowledges it.
//
// Ports:
//   Clk, Rst_n        clock, asynchronous active-low reset
//   i_Rx_DV           one-cycle strobe: i_Rx_Byte is valid
//   i_Rx_Byte         received byte
//   i_Frame_ack       consumer has taken the frame (releases HOLD)
//   o_Wr_en           sample-buffer write strobe, one cycle per sample
//   o_Wr_addr         sample index
//   o_Wr_data         sample {high byte, low byte}
//   o_Frame_valid     buffer holds a complete checksum-verified frame
//   o_Frame_err       one-cycle pulse on checksum failure or timeout
//   o_Err_code        01 checksum, 10 timeout, 00 none; held until next header
//   o_Rx_busy         high while a frame is being received
//   o_Rx_drop         one-cycle pulse for each byte discarded during HOLD

module uart_rx_frame_ctrl #(
    parameter int unsigned N_SAMPLES      = 187,
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  HEADER         = 8'h53
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              i_Rx_DV,
    input  logic [7:0]        i_Rx_Byte,
    input  logic              i_Frame_ack,
    output logic              o_Wr_en,
    output logic [ADDR_W-1:0] o_Wr_addr,
    output logic [15:0]       o_Wr_data,
    output logic              o_Frame_valid,
    output logic              o_Frame_err,
    output logic [1:0]        o_Err_code,
    output logic              o_Rx_busy,
    output logic              o_Rx_drop
);

    localparam int unsigned       TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(N_SAMPLES - 1);

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_CSUM = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;

    typedef enum logic [2:0] {StIdle, StHi, StLo, StChk, StHold} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [7:0]          csum_q, csum_d;
    logic [7:0]          hi_q, hi_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;

    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [15:0]         wr_data_q, wr_data_d;
    logic                frame_valid_q, frame_valid_d;
    logic                frame_err_q, frame_err_d;
    logic [1:0]          err_code_q, err_code_d;
    logic                rx_busy_q, rx_busy_d;
    logic                rx_drop_q, rx_drop_d;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        csum_d      = csum_q;
        hi_d        = hi_q;
        // Cleared unless an in-frame cycle passes without a byte.
        tmo_d       = '0;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;
        rx_drop_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_Rx_DV && (i_Rx_Byte == HEADER)) begin
                    idx_d      = '0;
                    csum_d     = '0;
                    err_code_d = ERR_NONE;
                    state_d    = StHi;
                end
            end

            StHi, StLo, StChk: begin
                if (i_Rx_DV) begin
                    // A byte on the terminal timeout cycle is still accepted.
                    unique case (state_q)
                        StHi: begin
                            hi_d    = i_Rx_Byte;
                            csum_d  = csum_q + i_Rx_Byte;
                            state_d = StLo;
                        end
                        StLo: begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = idx_q;
                            wr_data_d = {hi_q, i_Rx_Byte};
                            csum_d    = csum_q + i_Rx_Byte;
                            if (idx_q == IDX_LAST) begin
                                state_d = StChk;
                            end else begin
                                idx_d   = idx_q + 1'b1;
                                state_d = StHi;
                            end
                        end
                        default: begin
                            if (i_Rx_Byte == csum_q) begin
                                state_d = StHold;
                            end else begin
                                frame_err_d = 1'b1;
                                err_code_d  = ERR_CSUM;
                                state_d     = StIdle;
                            end
                        end
                    endcase
                end else if (tmo_q == TMO_LAST) begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_TMO;
                    state_d     = StIdle;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            StHold: begin
                // Bytes are never parsed here, even a header.
                rx_drop_d = i_Rx_DV;
                if (i_Frame_ack) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        frame_valid_d = (state_d == StHold);
        rx_busy_d     = (state_d == StHi) || (state_d == StLo) || (state_d == StChk);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            csum_q        <= '0;
            hi_q          <= '0;
            tmo_q         <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            err_code_q    <= ERR_NONE;
            rx_busy_q     <= 1'b0;
            rx_drop_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            csum_q        <= csum_d;
            hi_q          <= hi_d;
            tmo_q         <= tmo_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            err_code_q    <= err_code_d;
            rx_busy_q     <= rx_busy_d;
            rx_drop_q     <= rx_drop_d;
        end
    end

    assign o_Wr_en       = wr_en_q;
    assign o_Wr_addr     = wr_addr_q;
    assign o_Wr_data     = wr_data_q;
    assign o_Frame_valid = frame_valid_q;
    assign o_Frame_err   = frame_err_q;
    assign o_Err_code    = err_code_q;
    assign o_Rx_busy     = rx_busy_q;
    assign o_Rx_drop     = rx_drop_q;

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
Receive-side flow controller for the host link. It takes the byte stream from the UART receiver and parses framed ECG sample uploads: a header byte, N big-endian 16-bit samples, then an 8-bit checksum. Validated samples are written into the classifier's sample buffer, and `Frame_valid` is raised for the inference engine. This block is the inbound counterpart of the answer transmitter, which reports the class result after the engine finishes.

Parameters:
- N_SAMPLES, 187, samples per frame (one heartbeat window).
- ADDR_W, 8, sample-buffer address width; must satisfy 2^ADDR_W >= N_SAMPLES.
- TIMEOUT_CYCLES, 1000000, idle cycles allowed between bytes inside a frame before abort.
- HEADER, 8'h53, frame start byte ('S').

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- i_Rx_DV  in  1  one-cycle strobe from the UART receiver: `i_Rx_Byte` is valid.
- i_Rx_Byte  in  8  received byte.
- i_Frame_ack  in  1  consumer has taken the frame; releases HOLD.
- o_Wr_en  out  1  sample-buffer write strobe, one cycle per sample.
- o_Wr_addr  out  ADDR_W  sample index, 0..N_SAMPLES-1.
- o_Wr_data  out  16  sample, {high byte, low byte}.
- o_Frame_valid  out  1  buffer holds a complete checksum-verified frame.
- o_Frame_err  out  1  one-cycle pulse on checksum failure or timeout.
- o_Err_code  out  2  01 = checksum, 10 = timeout, 00 = none; holds until the next header is accepted.
- o_Rx_busy  out  1  high while in HI, LO or CHK.
- o_Rx_drop  out  1  one-cycle pulse when a byte is discarded during HOLD.

Behaviour:
- Reset (async assert, sync release): state = IDLE; all outputs 0; index, checksum and timeout counter cleared. Reset mid-frame abandons the frame. Buffer contents after such a reset are undefined.
- States: IDLE, HI, LO, CHK, HOLD. All actions happen on a cycle with i_Rx_DV = 1 unless noted.
- IDLE:
  - byte == HEADER: clear index and checksum, set o_Err_code = 00, go to HI.
  - any other byte: ignored, no pulse.
- HI: latch byte as the high byte; checksum += byte (mod 256); go to LO.
- LO:
  - Next cycle: o_Wr_en = 1 for exactly one cycle, o_Wr_addr = index, o_Wr_data = {hi, byte}. Latency from the low-byte strobe to o_Wr_en is one cycle.
  - checksum += byte.
  - If index == N_SAMPLES-1, go to CHK; else index++ and go to HI.
- CHK:
  - byte == checksum: go to HOLD and set o_Frame_valid = 1 next cycle.
  - mismatch: o_Frame_err pulse, o_Err_code = 01, go to IDLE.
- HOLD:
  - o_Frame_valid stays high until a cycle with i_Frame_ack = 1. Then o_Frame_valid = 0 next cycle and the state returns to IDLE.
  - Every i_Rx_DV in HOLD pulses o_Rx_drop. The byte is not parsed, including a HEADER.
  - i_Frame_ack and i_Rx_DV in the same cycle: the byte is dropped and the ack is honoured.
- i_Frame_ack outside HOLD: ignored.
- Timeout (HI/LO/CHK only):
  - Counter increments on each cycle without i_Rx_DV and clears on i_Rx_DV or on any state change.
  - When the counter reaches TIMEOUT_CYCLES-1 without a byte: o_Frame_err pulse, o_Err_code = 10, go to IDLE. No write occurs for a half-received sample.
  - i_Rx_DV arriving on the terminal cycle wins: the byte is processed and no timeout is raised.
- Checksum is the 8-bit sum over all 2·N_SAMPLES data bytes; the header and the checksum byte are excluded.
- o_Wr_en never asserts outside LO-to-HI and LO-to-CHK transitions. A failed frame may already have overwritten buffer entries, so the consumer must use only o_Frame_valid.
- o_Rx_busy = (state ∈ {HI, LO, CHK}), registered.

Test Plan:
- N_SAMPLES = 4, bytes 53 01 02 03 04 FF FE 00 10 17:
  - writes (0,0x0102), (1,0x0304), (2,0xFFFE), (3,0x0010), each a one-cycle o_Wr_en;
  - o_Frame_valid = 1 after the 0x17 byte;
  - i_Frame_ack clears it; state returns to IDLE.
- Same frame with last byte 0x18: four writes occur, then one o_Frame_err pulse, o_Err_code = 01, o_Frame_valid stays 0.
- Garbage 00 AA 7F before a valid frame: no writes and no pulses; the frame after 0x53 completes normally.
- TIMEOUT_CYCLES = 16: send 53 01 02 03, then idle 16 cycles:
  - o_Frame_err pulse, o_Err_code = 10;
  - exactly one write (0,0x0102);
  - next byte 0x53 restarts the frame and o_Err_code returns to 00.
- During HOLD send 53 11: two o_Rx_drop pulses and no writes; after i_Frame_ack, a new valid frame is accepted.
- Assert Rst_n low mid-frame (after 53 01): all outputs 0 asynchronously; after release, bytes 01 02 are ignored until a 0x53 arrives.
